// File: rtl/register_file_if.sv
// Bundle of register-file write-back and operand-read signals.
// The master drives the write and read indices; the slave (the register file) returns the operands.
interface register_file_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
);
    logic                  reg_write;
    logic [ADDR_WIDTH-1:0] write_reg;
    logic [DATA_WIDTH-1:0] write_data;
    logic [ADDR_WIDTH-1:0] read_reg1;
    logic [ADDR_WIDTH-1:0] read_reg2;
    logic [DATA_WIDTH-1:0] read_data1;
    logic [DATA_WIDTH-1:0] read_data2;

    // No handshake: a write is accepted on every clock edge where reg_write=1,
    // and the read data is combinational, so it is valid in the same cycle.
    modport master (
        output reg_write, write_reg, write_data, read_reg1, read_reg2,
        input  read_data1, read_data2
    );

    modport slave (
        input  reg_write, write_reg, write_data, read_reg1, read_reg2,
        output read_data1, read_data2
    );
endinterface

// File: rtl/register_file.sv
// Zeus general-purpose register bank: two asynchronous read ports and one synchronous write port.
// Register 0 always reads 0. The optional write-through bypass forwards same-cycle write data.
module register_file #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int BYPASS     = 1
) (
    input  logic           clock,
    input  logic           reset,
    register_file_if.slave rf
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs_q [DEPTH];
    logic [DATA_WIDTH-1:0] regs_d [DEPTH];

    always_comb begin
        regs_d = regs_q;
        if (rf.reg_write && rf.write_reg != '0) begin
            regs_d[rf.write_reg] = rf.write_data;
        end
        regs_d[0] = '0;
    end

    // Reset takes priority, so a write in the same cycle as reset is dropped.
    always_ff @(posedge clock) begin
        if (reset) begin
            regs_q <= '{default: '0};
        end else begin
            regs_q <= regs_d;
        end
    end

    // Each port resolves independently. The bypass is suppressed while reset is asserted.
    always_comb begin
        rf.read_data1 = regs_q[rf.read_reg1];
        if (rf.read_reg1 == '0) begin
            rf.read_data1 = '0;
        end else if (BYPASS != 0 && !reset && rf.reg_write && rf.write_reg == rf.read_reg1) begin
            rf.read_data1 = rf.write_data;
        end
    end

    always_comb begin
        rf.read_data2 = regs_q[rf.read_reg2];
        if (rf.read_reg2 == '0) begin
            rf.read_data2 = '0;
        end else if (BYPASS != 0 && !reset && rf.reg_write && rf.write_reg == rf.read_reg2) begin
            rf.read_data2 = rf.write_data;
        end
    end
endmodule

// File: tb/tb_register_file.sv
// Bench for register_file: drives identical stimulus into a BYPASS=1 and a BYPASS=0 instance
// and checks both against an array model every cycle, plus directed literal expectations.
module tb_register_file;
    localparam int DW = 32;
    localparam int AW = 5;

    // Clock and reset block
    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    logic          reg_write  = 1'b0;
    logic [AW-1:0] write_reg  = '0;
    logic [DW-1:0] write_data = '0;
    logic [AW-1:0] rr1        = '0;
    logic [AW-1:0] rr2        = '0;

    register_file_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) if_b1 ();
    register_file_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) if_b0 ();

    assign if_b1.reg_write  = reg_write;
    assign if_b1.write_reg  = write_reg;
    assign if_b1.write_data = write_data;
    assign if_b1.read_reg1  = rr1;
    assign if_b1.read_reg2  = rr2;
    assign if_b0.reg_write  = reg_write;
    assign if_b0.write_reg  = write_reg;
    assign if_b0.write_data = write_data;
    assign if_b0.read_reg1  = rr1;
    assign if_b0.read_reg2  = rr2;

    register_file #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BYPASS(1)) dut_b1 (
        .clock (clock),
        .reset (reset),
        .rf    (if_b1.slave)
    );

    register_file #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BYPASS(0)) dut_b0 (
        .clock (clock),
        .reset (reset),
        .rf    (if_b0.slave)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Reference model: one entry per register, as seen at the end of the previous edge
    logic [DW-1:0] model [2**AW];
    bit model_ok = 0;

    always @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 2**AW; i++) model[i] = '0;
            model_ok = 1;
        end else if (reg_write && write_reg != 0) begin
            model[write_reg] = write_data;
        end
    end

    function automatic logic [DW-1:0] exp_read(input logic [AW-1:0] idx, input bit byp);
        if (idx == 0) return '0;
        if (byp && !reset && reg_write && write_reg == idx) return write_data;
        return model[idx];
    endfunction

    // Every-cycle compare against the model, on the inactive clock edge
    always @(negedge clock) begin
        if (model_ok) begin
            check("model_b1_p1", if_b1.read_data1, exp_read(rr1, 1'b1));
            check("model_b1_p2", if_b1.read_data2, exp_read(rr2, 1'b1));
            check("model_b0_p1", if_b0.read_data1, exp_read(rr1, 1'b0));
            check("model_b0_p2", if_b0.read_data2, exp_read(rr2, 1'b0));
        end
    end

    // Scoreboard for directed literal expectations: b1 port1, b1 port2, b0 port1, b0 port2
    logic [DW-1:0] exp_q[$];

    task automatic expect4(input logic [DW-1:0] b1p1, input logic [DW-1:0] b1p2,
                           input logic [DW-1:0] b0p1, input logic [DW-1:0] b0p2);
        exp_q.push_back(b1p1);
        exp_q.push_back(b1p2);
        exp_q.push_back(b0p1);
        exp_q.push_back(b0p2);
    endtask

    task automatic check_directed(input string name);
        #2;
        check({name, "_b1_p1"}, if_b1.read_data1, exp_q.pop_front());
        check({name, "_b1_p2"}, if_b1.read_data2, exp_q.pop_front());
        check({name, "_b0_p1"}, if_b0.read_data1, exp_q.pop_front());
        check({name, "_b0_p2"}, if_b0.read_data2, exp_q.pop_front());
    endtask

    // Driver tasks
    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_write(input logic [AW-1:0] idx, input logic [DW-1:0] data);
        reg_write  = 1'b1;
        write_reg  = idx;
        write_data = data;
    endtask

    initial begin
        // 1. reset two cycles, then every index reads 0
        repeat (2) next_cycle();
        reset = 1'b0;
        for (int i = 0; i < 2**AW; i++) begin
            rr1 = AW'(i);
            rr2 = AW'(2**AW - 1 - i);
            expect4(32'h0, 32'h0, 32'h0, 32'h0);
            check_directed("reset_sweep");
            next_cycle();
        end

        // 2. write r5, read it back next cycle
        drive_write(5'd5, 32'hDEADBEEF);
        next_cycle();
        reg_write = 1'b0;
        rr1 = 5'd5;
        rr2 = 5'd6;
        expect4(32'hDEADBEEF, 32'h0, 32'hDEADBEEF, 32'h0);
        check_directed("write_r5");
        next_cycle();

        // 3. write to r0 is ignored, both in the write cycle and afterwards
        drive_write(5'd0, 32'hFFFFFFFF);
        rr1 = 5'd0;
        rr2 = 5'd0;
        expect4(32'h0, 32'h0, 32'h0, 32'h0);
        check_directed("r0_same");
        next_cycle();
        reg_write = 1'b0;
        expect4(32'h0, 32'h0, 32'h0, 32'h0);
        check_directed("r0_next");

        // 4. bypass versus no bypass on r7
        drive_write(5'd7, 32'h11);
        next_cycle();
        drive_write(5'd7, 32'h22);
        rr1 = 5'd7;
        rr2 = 5'd7;
        expect4(32'h22, 32'h22, 32'h11, 32'h11);
        check_directed("bypass_same");
        next_cycle();
        reg_write = 1'b0;
        expect4(32'h22, 32'h22, 32'h22, 32'h22);
        check_directed("bypass_next");

        // 5. reset overrides a simultaneous write, and the bypass is off during reset
        drive_write(5'd9, 32'h1234);
        next_cycle();
        reset = 1'b1;
        drive_write(5'd9, 32'h5678);
        rr1 = 5'd9;
        rr2 = 5'd9;
        expect4(32'h1234, 32'h1234, 32'h1234, 32'h1234);
        check_directed("reset_vs_write_during");
        next_cycle();
        reset = 1'b0;
        reg_write = 1'b0;
        expect4(32'h0, 32'h0, 32'h0, 32'h0);
        check_directed("reset_vs_write_after");

        // 6. back-to-back writes
        drive_write(5'd1, 32'd3);
        next_cycle();
        drive_write(5'd2, 32'd4);
        next_cycle();
        drive_write(5'd1, 32'd7);
        next_cycle();
        reg_write = 1'b0;
        rr1 = 5'd1;
        rr2 = 5'd2;
        expect4(32'd7, 32'd4, 32'd7, 32'd4);
        check_directed("back_to_back");
        next_cycle();

        // Randomized traffic, checked every cycle by the model compare
        for (int n = 0; n < 3000; n++) begin
            reset      = ($urandom_range(0, 99) == 0);
            reg_write  = ($urandom_range(0, 3) != 0);
            write_reg  = AW'($urandom_range(0, 2**AW - 1));
            write_data = $urandom;
            rr1 = ($urandom_range(0, 3) == 0) ? write_reg : AW'($urandom_range(0, 2**AW - 1));
            rr2 = ($urandom_range(0, 3) == 0) ? write_reg : AW'($urandom_range(0, 2**AW - 1));
            next_cycle();
        end
        reset = 1'b0;
        reg_write = 1'b0;
        next_cycle();

        // Final report
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
